rgb_pwm: RTL

RGB_PWM -- requirements
Module: rgb_pwm

---
 rtl/rgb_pwm_pkg.sv | 35 +++
 rtl/rgb_pwm_if.sv | 27 ++
 rtl/rgb_pwm_channel.sv | 41 ++++
 rtl/rgb_pwm.sv | 103 ++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM block: duty width, channel
// indices, handshake state encoding and the fade step helper.
package rgb_pwm_pkg;

    localparam int DUTY_W = 8;
    localparam int NUM_CH = 3;

    typedef logic [DUTY_W-1:0] duty_t;

    localparam duty_t DUTY_MAX = '1;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } channel_e;

    typedef enum logic {
        ST_READY   = 1'b0,
        ST_PENDING = 1'b1
    } cfg_state_e;

    // One fade step of cur toward tgt; returns cur unchanged once equal.
    function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
        duty_t res;
        res = cur;
        if (cur < tgt) begin
            res = cur + duty_t'(1);
        end else if (cur > tgt) begin
            res = cur - duty_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/rgb_pwm_if.sv
// Colour configuration handshake plus LED / period outputs of rgb_pwm.
// Handshake: a colour is taken on a rising edge where cfg_valid && cfg_ready.
interface rgb_pwm_if;
    import rgb_pwm_pkg::*;

    logic       cfg_valid;
    logic       cfg_ready;
    duty_t      cfg_r;
    duty_t      cfg_g;
    duty_t      cfg_b;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic       period_start;
    cfg_state_e dbg_state;

    modport master (
        output cfg_valid, cfg_r, cfg_g, cfg_b,
        input  cfg_ready, led_r, led_g, led_b, period_start, dbg_state
    );

    modport slave (
        input  cfg_valid, cfg_r, cfg_g, cfg_b,
        output cfg_ready, led_r, led_g, led_b, period_start, dbg_state
    );

endinterface

// File: rtl/rgb_pwm_channel.sv
// pwm_channel: one colour's active duty, fade step and registered compare.
// Fading toward the target is compiled in only with RGB_PWM_FADE_EN defined.
module pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  duty_t i_pwm_cnt,
    input  logic  i_boundary,
    input  duty_t i_target,
    output logic  o_led,
    output logic  o_settled
);

    duty_t r_duty;
    logic  r_led;
    duty_t w_duty_next;

`ifdef RGB_PWM_FADE_EN
    assign w_duty_next = step_toward(r_duty, i_target);
`else
    assign w_duty_next = i_target;
`endif

    // Settled means the duty after this boundary already equals the target.
    assign o_settled = (w_duty_next == i_target);
    assign o_led     = r_led;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_duty <= '0;
            r_led  <= 1'b0;
        end else begin
            if (i_boundary) begin
                r_duty <= w_duty_next;
            end
            r_led <= (r_duty == DUTY_MAX) || (i_pwm_cnt < r_duty);
        end
    end

endmodule

// File: rtl/rgb_pwm.sv
// rgb_pwm: three-channel LED PWM with prescaler, boundary-aligned colour
// updates and an optional per-boundary fade (macro RGB_PWM_FADE_EN).
module rgb_pwm
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic     clk,
    input  logic     rst,
    rgb_pwm_if.slave bus
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0]       r_pre;
    duty_t             r_pwm_cnt;
    logic              r_period_start;
    duty_t             r_target [NUM_CH];
    cfg_state_e        r_state;
    cfg_state_e        w_state_next;
    logic              w_tick;
    logic              w_boundary;
    logic              w_accept;
    logic              w_all_settled;
    duty_t             w_cfg [NUM_CH];
    logic [NUM_CH-1:0] w_led;
    logic [NUM_CH-1:0] w_settled;

    assign w_tick        = (r_pre == PRE_LAST);
    assign w_boundary    = w_tick && (r_pwm_cnt == DUTY_MAX);
    assign w_accept      = bus.cfg_valid && bus.cfg_ready;
    assign w_all_settled = &w_settled;

    always_comb begin
        w_cfg[CH_R] = bus.cfg_r;
        w_cfg[CH_G] = bus.cfg_g;
        w_cfg[CH_B] = bus.cfg_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre          <= '0;
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_pre          <= w_tick ? '0 : r_pre + 16'd1;
            r_period_start <= w_boundary;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + duty_t'(1);
            end
        end
    end

    // Targets only change while ready, so a pending colour is never overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_target[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_target[i] <= w_cfg[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_READY:   if (bus.cfg_valid) w_state_next = ST_PENDING;
            ST_PENDING: if (w_boundary && w_all_settled) w_state_next = ST_READY;
            default:    w_state_next = ST_READY;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_pwm_cnt  (r_pwm_cnt),
            .i_boundary (w_boundary),
            .i_target   (r_target[g]),
            .o_led      (w_led[g]),
            .o_settled  (w_settled[g])
        );
    end

    assign bus.cfg_ready    = (r_state == ST_READY);
    assign bus.led_r        = w_led[CH_R];
    assign bus.led_g        = w_led[CH_G];
    assign bus.led_b        = w_led[CH_B];
    assign bus.period_start = r_period_start;
    assign bus.dbg_state    = r_state;

endmodule
